async_fifo_top: RTL and testbench

- Parameterised FIFO buffer: 2**addr_size words of word_width bits each.
- Built in the dual-pointer style: Gray-coded read and write pointers, each passed to the other side through a 2-flop synchronizer.
- All logic runs on a single clock.
- Sits between a producer (wr/data_in/full) and a consumer (rd/data_out/empty); both flags are conservative.

---
 rtl/async_fifo_pkg.sv | 12 +
 rtl/async_fifo_top_sync_2ff.sv | 25 ++
 rtl/async_fifo_top.sv | 86 ++++++++
 tb/tb_async_fifo_top.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// Shared constants and helpers for the dual-pointer FIFO.
package async_fifo_pkg;

    localparam int ADDR_SIZE  = 3;
    localparam int WORD_WIDTH = 8;

    // Binary to reflected Gray code; callers cast the result to pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/async_fifo_top_sync_2ff.sv
// Two-flop synchronizer used to carry Gray pointers across to the other side.
module sync_2ff #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    logic [width-1:0] meta;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample the pre-edge values and the chain really delays by two clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/async_fifo_top.sv
// FIFO with Gray-coded read/write pointers, each synchronized to the other side.
module async_fifo_top
    import async_fifo_pkg::*;
#(
    parameter int addr_size  = ADDR_SIZE,
    parameter int word_width = WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [word_width-1:0] data_in,
    output logic [word_width-1:0] data_out,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = addr_size + 1;
    localparam int DEPTH = 1 << addr_size;
    // Inverting the two top Gray bits turns "same position" into "one lap ahead".
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (addr_size - 1);

    logic [word_width-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wbin, wgray, wbin_next;
    logic [PTR_W-1:0] rbin, rgray, rbin_next;
    logic [PTR_W-1:0] rq2_wptr, wq2_rptr;
    logic             wr_ok, rd_ok;

    // NOTE: every always_comb output gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        wr_ok     = wr && !full;
        rd_ok     = rd && !empty;
        wbin_next = wbin;
        rbin_next = rbin;
        if (wr_ok) wbin_next = wbin + PTR_W'(1);
        if (rd_ok) rbin_next = rbin + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbin  <= '0;
            wgray <= '0;
            rbin  <= '0;
            rgray <= '0;
        end else begin
            wbin  <= wbin_next;
            wgray <= PTR_W'(bin2gray(32'(wbin_next)));
            rbin  <= rbin_next;
            rgray <= PTR_W'(bin2gray(32'(rbin_next)));
        end
    end

    // NOTE: the storage array has no reset; stale words are unreachable
    // because the pointers, not the contents, define what is readable.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wbin[addr_size-1:0]] <= data_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
        end else if (rd_ok) begin
            data_out <= mem[rbin[addr_size-1:0]];
        end
    end

    sync_2ff #(.width(PTR_W)) u_sync_w2r (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (wgray),
        .q     (rq2_wptr)
    );

    sync_2ff #(.width(PTR_W)) u_sync_r2w (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (rgray),
        .q     (wq2_rptr)
    );

    assign empty = (rgray == rq2_wptr);
    assign full  = (wgray == (wq2_rptr ^ FULL_MASK));

endmodule

// File: tb/tb_async_fifo_top.sv
// Directed self-checking bench for async_fifo_top with hand-computed expectations.
module tb_async_fifo_top;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr;
    logic       rd;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fill_data [8]  = '{8'd104, 8'd105, 8'd95, 8'd116, 8'd104, 8'd101, 8'd114, 8'd101};
    logic [7:0] strm_data [14] = '{8'd79, 8'd114, 8'd105, 8'd103, 8'd105, 8'd110, 8'd97,
                                   8'd108, 8'd95, 8'd70, 8'd73, 8'd70, 8'd73, 8'd73};
    logic       fill_empty [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       fill_full  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       drain_full [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    async_fifo_top #(.addr_size(3), .word_width(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr       (wr),
        .rd       (rd),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; the rising edge acts; outputs are read on the next falling edge.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        wr      = w;
        rd      = r;
        data_in = d;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        wr      = 1'b0;
        rd      = 1'b0;
        data_in = 8'd0;
        @(negedge clk);
        @(negedge clk);
        check_bit("reset_empty", empty, 1'b1);
        check_bit("reset_full", full, 1'b0);
        check_word("reset_dout", data_out, 8'd0);
        reset_n = 1'b1;

        step(1'b0, 1'b1, 8'd0);
        check_word("rd_empty_dout", data_out, 8'd0);
        check_bit("rd_empty_empty", empty, 1'b1);

        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, fill_data[i]);
            check_bit($sformatf("fill_empty_%0d", i), empty, fill_empty[i]);
            check_bit($sformatf("fill_full_%0d", i), full, fill_full[i]);
        end
        step(1'b1, 1'b0, 8'd79);
        check_bit("overfill_full", full, 1'b1);
        check_bit("overfill_empty", empty, 1'b0);
        check_word("overfill_dout", data_out, 8'd0);

        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'd0);
            check_word($sformatf("drain_dout_%0d", i), data_out, fill_data[i]);
            check_bit($sformatf("drain_full_%0d", i), full, drain_full[i]);
            check_bit($sformatf("drain_empty_%0d", i), empty, (i == 7) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 8'd0);
            check_word($sformatf("extra_rd_dout_%0d", i), data_out, 8'd101);
            check_bit($sformatf("extra_rd_empty_%0d", i), empty, 1'b1);
        end

        // Reads trail writes by three edges because empty clears two edges after a write.
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b1, strm_data[i]);
            check_word($sformatf("stream_dout_%0d", i), data_out, (i < 3) ? 8'd101 : strm_data[i-3]);
            check_bit($sformatf("stream_full_%0d", i), full, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'd0);
            check_word($sformatf("stream_tail_dout_%0d", i), data_out, strm_data[11+i]);
        end
        check_bit("stream_drained_empty", empty, 1'b1);

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'd100);
            check_word($sformatf("gated_dout_%0d", i), data_out, 8'd73);
            check_bit($sformatf("gated_empty_%0d", i), empty, 1'b1);
        end

        step(1'b1, 1'b0, 8'd1);
        step(1'b1, 1'b0, 8'd2);
        step(1'b1, 1'b0, 8'd3);
        check_bit("mid_empty_before_rd", empty, 1'b0);
        step(1'b0, 1'b1, 8'd0);
        check_word("mid_rd_dout", data_out, 8'd1);
        wr      = 1'b0;
        rd      = 1'b0;
        reset_n = 1'b0;
        #2;
        check_bit("midrst_empty", empty, 1'b1);
        check_bit("midrst_full", full, 1'b0);
        check_word("midrst_dout", data_out, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;

        step(1'b1, 1'b0, 8'd42);
        check_bit("post_rst_empty_0", empty, 1'b1);
        step(1'b0, 1'b0, 8'd0);
        check_bit("post_rst_empty_1", empty, 1'b1);
        step(1'b0, 1'b0, 8'd0);
        check_bit("post_rst_empty_2", empty, 1'b0);
        step(1'b0, 1'b1, 8'd0);
        check_word("post_rst_dout", data_out, 8'd42);
        check_bit("post_rst_empty_3", empty, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
